// File: rtl/vga_pattern_scheduler.sv
// Test-pattern scheduler: UART commands pick or auto-cycle the VGA pattern, applied only at frame start.
// Optional UART acknowledge FSM when VGA_SCHED_ACK_EN is defined; acks wait while the transmitter is busy.
module vga_pattern_scheduler #(
    parameter int NUM_PATTERNS       = 8,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_VSync,
    input  logic       i_TX_Active,
    output logic [3:0] o_Pattern,
    output logic       o_Auto_Mode,
    output logic       o_Pending,
    output logic       o_Cmd_Error,
    output logic       o_Ack_DV,
    output logic [7:0] o_Ack_Byte
);
    localparam logic [3:0] PAT_LAST  = 4'(NUM_PATTERNS - 1);
    localparam logic [4:0] PAT_COUNT = 5'(NUM_PATTERNS);
    localparam logic [7:0] CNT_LAST  = 8'(FRAMES_PER_PATTERN - 1);

    typedef enum logic {SCHED_IDLE, SCHED_PENDING} sched_state_t;

    sched_state_t sched_state, sched_state_nxt;
    logic         vsync_q, vsync_qq, frame_start;
    logic [3:0]   pattern, pattern_nxt;
    logic [3:0]   pend_val, pend_val_nxt;
    logic [7:0]   frame_cnt, frame_cnt_nxt;
    logic         auto_mode, auto_mode_nxt;
    logic         cmd_error;
    logic         cmd_set, cmd_auto, cmd_manual, cmd_next, cmd_bad;

    function automatic logic [3:0] next_pattern(input logic [3:0] cur);
        return (cur >= PAT_LAST) ? 4'd0 : cur + 4'd1;
    endfunction

    // Edge detect on the registered copy, so frame start is seen one cycle after VSync rises.
    assign frame_start = vsync_q & ~vsync_qq;

    assign cmd_set    = i_RX_DV && (i_RX_Byte[7:4] == 4'h3) && ({1'b0, i_RX_Byte[3:0]} < PAT_COUNT);
    assign cmd_auto   = i_RX_DV && (i_RX_Byte == 8'h41);
    assign cmd_manual = i_RX_DV && (i_RX_Byte == 8'h4D);
    assign cmd_next   = i_RX_DV && (i_RX_Byte == 8'h4E);
    assign cmd_bad    = i_RX_DV && !(cmd_set || cmd_auto || cmd_manual || cmd_next);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sched_state <= SCHED_IDLE;
            vsync_q     <= 1'b0;
            vsync_qq    <= 1'b0;
            pattern     <= 4'd0;
            pend_val    <= 4'd0;
            frame_cnt   <= 8'd0;
            auto_mode   <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            sched_state <= sched_state_nxt;
            vsync_q     <= i_VSync;
            vsync_qq    <= vsync_q;
            pattern     <= pattern_nxt;
            pend_val    <= pend_val_nxt;
            frame_cnt   <= frame_cnt_nxt;
            auto_mode   <= auto_mode_nxt;
            cmd_error   <= cmd_bad;
        end
    end

    // Frame-start effects use the pre-command state; a command in the same cycle only arms the next frame.
    always_comb begin
        sched_state_nxt = sched_state;
        pattern_nxt     = pattern;
        pend_val_nxt    = pend_val;
        frame_cnt_nxt   = frame_cnt;
        auto_mode_nxt   = auto_mode;

        if (frame_start) begin
            sched_state_nxt = SCHED_IDLE;
            if (sched_state == SCHED_PENDING) begin
                pattern_nxt   = pend_val;
                frame_cnt_nxt = 8'd0;
            end else if (auto_mode) begin
                if (frame_cnt >= CNT_LAST) begin
                    frame_cnt_nxt = 8'd0;
                    pattern_nxt   = next_pattern(pattern);
                end else begin
                    frame_cnt_nxt = frame_cnt + 8'd1;
                end
            end
        end

        if (cmd_set) begin
            pend_val_nxt    = i_RX_Byte[3:0];
            sched_state_nxt = SCHED_PENDING;
            auto_mode_nxt   = 1'b0;
        end
        if (cmd_next) begin
            pend_val_nxt    = next_pattern((sched_state == SCHED_PENDING) ? pend_val : pattern);
            sched_state_nxt = SCHED_PENDING;
        end
        if (cmd_auto) begin
            auto_mode_nxt = 1'b1;
            frame_cnt_nxt = 8'd0;
        end
        if (cmd_manual) begin
            auto_mode_nxt = 1'b0;
        end
    end

    assign o_Pattern   = pattern;
    assign o_Auto_Mode = auto_mode;
    assign o_Pending   = (sched_state == SCHED_PENDING);
    assign o_Cmd_Error = cmd_error;

`ifdef VGA_SCHED_ACK_EN
    typedef enum logic [1:0] {ACK_IDLE, ACK_WAIT, ACK_SEND} ack_state_t;

    ack_state_t ack_state, ack_state_nxt;
    logic [7:0] ack_byte;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ack_state <= ACK_IDLE;
            ack_byte  <= 8'h00;
        end else begin
            ack_state <= ack_state_nxt;
            if (i_RX_DV) begin
                ack_byte <= cmd_bad ? 8'h3F : 8'h4B;
            end
        end
    end

    // A new command always re-queues, replacing any ack not yet sent.
    always_comb begin
        ack_state_nxt = ack_state;
        case (ack_state)
            ACK_IDLE: ack_state_nxt = ACK_IDLE;
            ACK_WAIT: if (!i_TX_Active) ack_state_nxt = ACK_SEND;
            ACK_SEND: ack_state_nxt = ACK_IDLE;
            default:  ack_state_nxt = ACK_IDLE;
        endcase
        if (i_RX_DV) begin
            ack_state_nxt = ACK_WAIT;
        end
    end

    assign o_Ack_DV   = (ack_state == ACK_SEND);
    assign o_Ack_Byte = ack_byte;
`else
    logic unused_tx_active;
    assign unused_tx_active = i_TX_Active;
    assign o_Ack_DV   = 1'b0;
    assign o_Ack_Byte = 8'h00;
`endif

endmodule

// File: doc/vga_pattern_scheduler.md
VGA_PATTERN_SCHEDULER -- requirements
Module: vga_pattern_scheduler

Interface
REQ-001 Parameter NUM_PATTERNS, default 8, number of selectable test patterns (2..16).
REQ-002 Parameter FRAMES_PER_PATTERN, default 60, frames each pattern is shown in auto mode (1..255).
REQ-003 i_Clk  input  1  system clock, 25 MHz; all logic on rising edge.
REQ-004 i_Rst_L  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 i_RX_DV  input  1  one-cycle strobe; i_RX_Byte valid.
REQ-006 i_RX_Byte  input  8  received UART command byte.
REQ-007 i_VSync  input  1  vertical sync from sync generator, high during active rows; rising edge = frame start.
REQ-008 i_TX_Active  input  1  UART transmitter busy.
REQ-009 o_Pattern  output  4  test pattern index driven to the pattern generator.
REQ-010 o_Auto_Mode  output  1  high while auto-cycle mode is active.
REQ-011 o_Pending  output  1  high while a manual pattern change awaits frame start.
REQ-012 o_Cmd_Error  output  1  one-cycle pulse on an invalid command.
REQ-013 o_Ack_DV  output  1  one-cycle strobe to UART transmitter.
REQ-014 o_Ack_Byte  output  8  acknowledge byte, valid with o_Ack_DV.

Function
REQ-015 Frame start is detected from a registered copy of i_VSync (0 then 1); detection lags i_VSync by one cycle.
REQ-016 Command 0x30..0x3F: low nibble N; N < NUM_PATTERNS loads pending register with N, sets o_Pending, clears o_Auto_Mode; N >= NUM_PATTERNS is an error.
REQ-017 Command 0x41 ('A'): sets o_Auto_Mode, clears frame counter; pattern unchanged.
REQ-018 Command 0x4D ('M'): clears o_Auto_Mode; pattern unchanged.
REQ-019 Command 0x4E ('N'): pending = (current or pending value)+1, wrapping NUM_PATTERNS-1 -> 0; sets o_Pending; auto mode unchanged.
REQ-020 Any other byte: o_Cmd_Error pulses the cycle after i_RX_DV; no state change.
REQ-021 Scheduler FSM states IDLE and PENDING: IDLE -> PENDING on valid pattern command; PENDING -> IDLE at frame start, o_Pattern <= pending value same cycle.
REQ-022 o_Pattern changes only at a detected frame start, never mid-frame.
REQ-023 Command in PENDING overwrites pending value (last wins); no extra frame wait.
REQ-024 Command strobe coinciding with frame-start detection is applied at the following frame start, not the current one.
REQ-025 Auto mode: 8-bit frame counter increments each frame start; at FRAMES_PER_PATTERN-1 it clears and o_Pattern advances by one with wrap.
REQ-026 Pending manual change and auto advance on same frame start: manual value wins, frame counter clears.
REQ-027 Ack FSM states ACK_IDLE, ACK_WAIT, ACK_SEND: each command queues ack 0x4B ('K') if valid, 0x3F ('?') if invalid.
REQ-028 ACK_WAIT holds while i_TX_Active=1; ACK_SEND asserts o_Ack_DV exactly one cycle then returns to ACK_IDLE.
REQ-029 Command arriving while ack queued replaces queued byte; at most one ack outstanding.

Reset
REQ-030 On i_Rst_L=0, immediately: o_Pattern=0, o_Auto_Mode=0, o_Pending=0, o_Cmd_Error=0, o_Ack_DV=0, o_Ack_Byte=0, frame counter=0, both FSMs idle, VSync register=0.
REQ-031 Reset mid-PENDING or mid-ACK_WAIT discards pending change and ack; no output pulses after release until a new command.
REQ-032 Deassertion synchronous to i_Clk; first frame start after release is detectable.

Configuration
REQ-033 Macro VGA_SCHED_ACK_EN: defined -> ack FSM per REQ-027..029; undefined -> ack logic absent, o_Ack_DV and o_Ack_Byte constant 0, i_TX_Active ignored.

Verification
REQ-034 Byte 0x33 mid-frame -> o_Pending=1, o_Pattern stays 0 until next frame start, then o_Pattern=3, o_Pending=0.
REQ-035 Byte 0x39 with NUM_PATTERNS=8 -> o_Cmd_Error one pulse, o_Pattern unchanged, ack 0x3F.
REQ-036 Byte 0x41, FRAMES_PER_PATTERN=2 -> o_Pattern 0,0,1,1,...,7,7,0 over 16 frames, wrap at 7.
REQ-037 Byte 0x35 on same cycle frame start detected -> o_Pattern=5 only at the following frame start.
REQ-038 VGA_SCHED_ACK_EN defined, i_TX_Active=1 for 300 cycles, byte 0x4E -> o_Ack_DV withheld, pulses once with 0x4B after i_TX_Active falls.
REQ-039 i_Rst_L low during PENDING with pending=6 -> after release o_Pattern=0 and stays 0 across next frame start.
